// File: rtl/fp_add_sum_normalizer_if.sv
// rtl/fp_add_sum_normalizer_if.sv - operand/result handshake bundle for the FP add sum normalizer
interface fp_add_sum_normalizer_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    sign_big;
    logic                    sign_little;
    logic [EXP_W-1:0]        exp_in;
    logic [MANT_W:0]         sig_big;
    logic [MANT_W:0]         sig_little;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+MANT_W:0]   result;
    logic                    busy;

    modport master (
        output in_valid, sign_big, sign_little, exp_in, sig_big, sig_little, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, sign_big, sign_little, exp_in, sig_big, sig_little, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/fp_add_sum_normalizer.sv
// rtl/fp_add_sum_normalizer.sv - significand add/sub and renormalize to IEEE single (FAST_NORM_EN: one-cycle LZC normalize)
module fp_add_sum_normalizer #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input logic                     clk,
    input logic                     rst_n,
    fp_add_sum_normalizer_if.slave  bus
);
    localparam int SIG_W = MANT_W + 1;
    localparam int RES_W = 1 + EXP_W + MANT_W;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_NORM, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                sign_q, sub_q, special_q, load;
    logic [SIG_W-1:0]    sig_big_q, sig_little_q;
    logic [SIG_W-1:0]    sum_q, sum_d, norm_sum;
    logic [EXP_W-1:0]    exp_q, exp_d, norm_exp, inc_exp;
    logic [RES_W-1:0]    result_q, result_d;
    logic [SIG_W:0]      add_sum;

    // Exponent field collapses to zero whenever the integer bit is clear (denormal).
    function automatic logic [RES_W-1:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                              input logic [SIG_W-1:0] m);
        pack = {s, (m[MANT_W] ? e : {EXP_W{1'b0}}), m[MANT_W-1:0]};
    endfunction

`ifdef FAST_NORM_EN
    int lz, lim, sft;

    function automatic int lzc(input logic [SIG_W-1:0] v);
        lzc = SIG_W;
        for (int i = 0; i < SIG_W; i++)
            if (v[i]) lzc = SIG_W - 1 - i;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        exp_d    = exp_q;
        result_d = result_q;
        load     = 1'b0;
        add_sum  = '0;
        inc_exp  = '0;
        norm_sum = sum_q;
        norm_exp = exp_q;
`ifdef FAST_NORM_EN
        lz  = 0;
        lim = 0;
        sft = 0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    exp_d   = (bus.exp_in == '0) ? EXP_ONE : bus.exp_in;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                add_sum = sub_q ? ({1'b0, sig_big_q} - {1'b0, sig_little_q})
                                : ({1'b0, sig_big_q} + {1'b0, sig_little_q});
                inc_exp = exp_q + EXP_ONE;
                state_d = S_DONE;
                if (special_q) begin
                    result_d = {sign_q, EXP_MAX, sig_big_q[MANT_W-1:0]};
                end else if (add_sum == '0) begin
                    result_d = '0;
                end else if (add_sum[SIG_W]) begin
                    // Carry out: truncating right shift; saturating to Inf clears the fraction.
                    result_d = {sign_q, inc_exp,
                                (inc_exp == EXP_MAX) ? {MANT_W{1'b0}} : add_sum[MANT_W:1]};
                end else if (add_sum[MANT_W]) begin
                    result_d = pack(sign_q, exp_q, add_sum[MANT_W:0]);
                end else begin
                    sum_d   = add_sum[MANT_W:0];
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
`ifdef FAST_NORM_EN
                lz       = lzc(sum_q);
                lim      = int'(exp_q) - 1;
                sft      = (lz < lim) ? lz : lim;
                norm_sum = sum_q << sft;
                norm_exp = exp_q - EXP_W'(sft);
                result_d = pack(sign_q, norm_exp, norm_sum);
                state_d  = S_DONE;
`else
                if (!sum_q[MANT_W] && (exp_q > EXP_ONE)) begin
                    norm_sum = sum_q << 1;
                    norm_exp = exp_q - EXP_ONE;
                end
                sum_d = norm_sum;
                exp_d = norm_exp;
                if (norm_sum[MANT_W] || (norm_exp == EXP_ONE)) begin
                    result_d = pack(sign_q, norm_exp, norm_sum);
                    state_d  = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sign_q       <= 1'b0;
            sub_q        <= 1'b0;
            special_q    <= 1'b0;
            sig_big_q    <= '0;
            sig_little_q <= '0;
            sum_q        <= '0;
            exp_q        <= '0;
            result_q     <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            if (load) begin
                sign_q       <= bus.sign_big;
                sub_q        <= bus.sign_big ^ bus.sign_little;
                special_q    <= (bus.exp_in == EXP_MAX);
                sig_big_q    <= bus.sig_big;
                sig_little_q <= bus.sig_little;
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
endmodule
